timepulse_gen: RTL and testbench
================================

TIMEPULSE_GEN -- requirements
Module: timepulse_gen

Interface
REQ-001 Parameter DIV, default 2: clk cycles per timepulse; legal range 1..255.
REQ-002 Parameter PWR_DELAY, default 4: timepulse periods spent in WARM before RUN; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port stby  input  1  standby request; sampled only at the end of T12.
REQ-006 Port mstp  input  1  monitor stop request; exists only with TPG_STEP_EN.
REQ-007 Port mstrt  input  1  monitor single-step pulse; exists only with TPG_STEP_EN.
REQ-008 Port tp  output  12  one-hot timepulses; bit0=T01 through bit11=T12; all-zero when not running.
REQ-009 Port mct_end  output  1  one-clk pulse on the last clk of T12.
REQ-010 Port mct_cnt  output  16  count of completed memory cycles (MCTs).
REQ-011 Port state  output  2  FSM state: 0=STBY, 1=WARM, 2=RUN, 3=HALT.

Function
REQ-012 The prescaler SHALL count 0..DIV-1; a "tick" occurs on the clk where the count equals DIV-1.
- DIV=1: a tick occurs every clk.
REQ-013 In RUN, tp SHALL advance one position per tick: T01..T12, then T12->T01.
REQ-014 Exactly one tp bit SHALL be high in RUN; tp SHALL be 0 in STBY, WARM and HALT.
REQ-015 WARM SHALL count PWR_DELAY ticks and then enter RUN, with tp=T01 on the following clk.
REQ-016 The end of T12 SHALL be the tick while tp=T12. At that point:
- mct_end=1 for that clk;
- mct_cnt increments, wrapping 0xFFFF->0x0000.
REQ-017 At the end of T12 the next state SHALL be chosen in this priority:
- stby=1 -> STBY;
- else mstp=1 -> HALT;
- else stay in RUN.
REQ-018 State and tp SHALL change only at tick boundaries.
- Requests mid-cycle (T01..T11) take effect at that MCT's T12 end, never mid-MCT.
REQ-019 From STBY, stby=0 SHALL enter WARM on the next clk; the prescaler restarts at 0.
REQ-020 From HALT:
- stby=1 -> STBY (priority over all else);
- mstp=0 -> RUN starting at T01;
- mstrt=1 with mstp=1 -> run exactly one MCT (T01..T12), then return to HALT.
REQ-021 While a single-step MCT is in progress, further mstrt pulses SHALL be ignored.

Reset
REQ-022 With rst=1 at a posedge, the next state SHALL be:
- state=WARM, tp=0, mct_end=0, mct_cnt=0;
- prescaler=0, WARM counter=0, step flag clear.
REQ-023 Reset asserted mid-MCT SHALL abort that MCT immediately, with no mct_end and no mct_cnt increment.
REQ-024 rst SHALL take priority over every other input.

Configuration
REQ-025 Macro TPG_STEP_EN SHALL control the monitor stop/step feature.
- Defined: mstp and mstrt ports exist; the HALT state and single-step behaviour are present.
- Undefined: no mstp or mstrt ports; HALT is unreachable; the state output never reads 3; RUN exits only to STBY.

Structure
REQ-026 Package timepulse_pkg SHALL hold:
- the state enum (STBY, WARM, RUN, HALT);
- NUM_TP=12;
- tp one-hot constants T01..T12.
REQ-027 The prescaler SHALL be a sub-module tp_prescaler (parameter DIV; ports clk, rst, clr; output tick).

Verification
REQ-028 DIV=2, PWR_DELAY=4, reset released -> tp=0 for 8 clks, then T01, then T02 two clks later.
REQ-029 Free RUN for 3 MCTs -> mct_end pulses every 24 clks and mct_cnt=3; tp is always one-hot.
REQ-030 stby raised during T05 -> T06..T12 complete, then STBY with tp=0; stby dropped -> WARM, then T01 after PWR_DELAY*DIV clks.
REQ-031 Preload mct_cnt to 0xFFFF via forced run -> the next mct_end yields 0x0000.
REQ-032 TPG_STEP_EN, mstp held, mstrt pulsed twice during the step -> exactly one MCT runs (12 tp pulses, mct_cnt+1), then HALT.
REQ-033 rst asserted during T07 -> the next clk shows WARM, tp=0, mct_cnt=0, and no mct_end.

Source files
------------

// File: rtl/timepulse_pkg.sv
// Shared types and constants for the timepulse generator.
//   tpg_state_e : controller state encoding (STBY/WARM/RUN/HALT)
//   NUM_TP      : number of timepulses per memory cycle (MCT)
//   T01..T12    : one-hot timepulse constants
//   tp_next()   : advance a one-hot timepulse vector by one position
package timepulse_pkg;

  localparam int NUM_TP = 12;

  typedef enum logic [1:0] {
    STBY = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } tpg_state_e;

  typedef logic [NUM_TP-1:0] tp_vec_t;

  localparam tp_vec_t T01 = 12'h001;
  localparam tp_vec_t T02 = 12'h002;
  localparam tp_vec_t T03 = 12'h004;
  localparam tp_vec_t T04 = 12'h008;
  localparam tp_vec_t T05 = 12'h010;
  localparam tp_vec_t T06 = 12'h020;
  localparam tp_vec_t T07 = 12'h040;
  localparam tp_vec_t T08 = 12'h080;
  localparam tp_vec_t T09 = 12'h100;
  localparam tp_vec_t T10 = 12'h200;
  localparam tp_vec_t T11 = 12'h400;
  localparam tp_vec_t T12 = 12'h800;

  // Rotate left: T01->T02 ... T11->T12, T12->T01.
  function automatic tp_vec_t tp_next(input tp_vec_t cur);
    return {cur[NUM_TP-2:0], cur[NUM_TP-1]};
  endfunction

endpackage

// File: rtl/tp_prescaler.sv
// Prescaler for the timepulse generator: counts 0..DIV-1 and flags a tick
// on the clk where the count equals DIV-1 (every clk when DIV=1).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, count returns to 0
//   clr  - synchronous clear, holds the count at 0 while high
//   tick - high on the last clk of each prescaler period
module tp_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/timepulse_gen.sv
// Timepulse generator: after a warm-up of PWR_DELAY timepulse periods it
// cycles one-hot timepulses T01..T12, each DIV clks long, forming memory
// cycles (MCTs). Standby/halt requests only act at the end of T12.
// Optional feature macro: TPG_STEP_EN adds the monitor stop/single-step
// inputs and the HALT state. Without it HALT is unreachable.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset (enters WARM)
//   stby    - standby request, sampled at end of T12 and in STBY/HALT
//   mstp    - monitor stop request (TPG_STEP_EN only)
//   mstrt   - monitor single-step pulse (TPG_STEP_EN only)
//   tp      - one-hot timepulses, bit0=T01 .. bit11=T12, zero unless RUN
//   mct_end - one-clk pulse on the last clk of T12
//   mct_cnt - completed-MCT counter, wraps at 16 bits
//   state   - 0=STBY 1=WARM 2=RUN 3=HALT
module timepulse_gen
  import timepulse_pkg::*;
#(
  parameter int DIV       = 2,
  parameter int PWR_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stby,
`ifdef TPG_STEP_EN
  input  logic              mstp,
  input  logic              mstrt,
`endif
  output logic [NUM_TP-1:0] tp,
  output logic              mct_end,
  output logic [15:0]       mct_cnt,
  output logic [1:0]        state
);

  localparam logic [7:0] WARM_LAST = 8'(PWR_DELAY - 1);

  tpg_state_e  state_q, state_d;
  tp_vec_t     tp_q, tp_d;
  logic [7:0]  warm_q, warm_d;
  logic [15:0] mct_cnt_q, mct_cnt_d;
  logic        step_q, step_d;
  logic        end_of_mct;
  logic        tick;
  logic        presc_clr;
  logic        halt_req;
  logic        step_req;

`ifdef TPG_STEP_EN
  assign halt_req = mstp;
  assign step_req = mstrt;
`else
  assign halt_req = 1'b0;
  assign step_req = 1'b0;
`endif

  // Prescaler is parked at 0 while idle so the first timepulse after
  // leaving STBY or HALT lasts a full DIV clks.
  assign presc_clr = (state_q == STBY) || (state_q == HALT);

  tp_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .tick (tick)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tp_d       = tp_q;
    warm_d     = warm_q;
    mct_cnt_d  = mct_cnt_q;
    step_d     = step_q;
    end_of_mct = 1'b0;

    unique case (state_q)
      STBY: begin
        if (!stby) begin
          state_d = WARM;
          warm_d  = '0;
        end
      end
      WARM: begin
        if (tick) begin
          if (warm_q == WARM_LAST) begin
            state_d = RUN;
            tp_d    = T01;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (tick) begin
          tp_d = tp_next(tp_q);
          if (tp_q == T12) begin
            end_of_mct = 1'b1;
            mct_cnt_d  = mct_cnt_q + 1'b1;
            step_d     = 1'b0;
            if (stby) begin
              state_d = STBY;
              tp_d    = '0;
            end else if (halt_req || step_q) begin
              // A single-step MCT always returns to HALT.
              state_d = HALT;
              tp_d    = '0;
            end
          end
        end
      end
      HALT: begin
        if (stby) begin
          state_d = STBY;
        end else if (!halt_req) begin
          state_d = RUN;
          tp_d    = T01;
        end else if (step_req) begin
          state_d = RUN;
          tp_d    = T01;
          step_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WARM;
      tp_q      <= '0;
      warm_q    <= '0;
      mct_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tp_q      <= tp_d;
      warm_q    <= warm_d;
      mct_cnt_q <= mct_cnt_d;
      step_q    <= step_d;
    end
  end

  // Masked by rst so an MCT aborted on its final clk reports no end.
  assign mct_end = end_of_mct & ~rst;
  assign tp      = tp_q;
  assign mct_cnt = mct_cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_timepulse_gen.sv
// Self-checking bench for timepulse_gen: a clock-count model of the
// timepulse sequence checked every cycle, plus directed scenarios with
// literal expectations. Step/halt scenarios run when TPG_STEP_EN is defined.
module tb_timepulse_gen;

  localparam int DIV = 2;
  localparam int PWR = 4;
  localparam int NTP = 12;
  localparam int MCT = NTP * DIV;

`ifdef TPG_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        stby  = 1'b0;
  logic        mstp  = 1'b0;
  logic        mstrt = 1'b0;
  logic [11:0] tp;
  logic        mct_end;
  logic [15:0] mct_cnt;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  timepulse_gen #(.DIV(DIV), .PWR_DELAY(PWR)) dut (
    .clk     (clk),
    .rst     (rst),
    .stby    (stby),
`ifdef TPG_STEP_EN
    .mstp    (mstp),
    .mstrt   (mstrt),
`endif
    .tp      (tp),
    .mct_end (mct_end),
    .mct_cnt (mct_cnt),
    .state   (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: mode plus clocks elapsed since entering it. In RUN the timepulse
  // index is m_k/DIV and the MCT ends at m_k == MCT-1.
  int          m_mode  = 0;  // 0 STBY, 1 WARM, 2 RUN, 3 HALT
  int          m_k     = 0;
  int unsigned m_cnt   = 0;
  bit          m_step  = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 1; m_k = 0; m_cnt = 0; m_step = 1'b0; m_valid = 1'b1;
    end else begin
      case (m_mode)
        0: if (!stby) begin m_mode = 1; m_k = 0; end
        1: if (m_k == PWR * DIV - 1) begin m_mode = 2; m_k = 0; end else m_k++;
        2: begin
          if (m_k == MCT - 1) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_k   = 0;
            if (stby) m_mode = 0;
            else if (STEP_EN && (mstp || m_step)) m_mode = 3;
            m_step = 1'b0;
          end else begin
            m_k++;
          end
        end
        3: begin
          if (stby) m_mode = 0;
          else if (!mstp) begin m_mode = 2; m_k = 0; end
          else if (mstrt) begin m_mode = 2; m_k = 0; m_step = 1'b1; end
        end
        default: m_mode = 1;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always begin : cmp
    int exp_tp;
    int exp_end;
    @(negedge clk);
    #2;
    if (m_valid) begin
      exp_tp  = (m_mode == 2) ? (1 << (m_k / DIV)) : 0;
      exp_end = (m_mode == 2 && m_k == MCT - 1 && !rst) ? 1 : 0;
      check("model_state", 32'(state), m_mode);
      check("model_tp", 32'(tp), exp_tp);
      check("model_mct_end", 32'(mct_end), exp_end);
      check("model_mct_cnt", 32'(mct_cnt), m_cnt);
      if (state == 2'd2) check("tp_onehot", $countones(tp), 1);
    end
  end

  task automatic wait_end(input string name, output int at);
    int seen;
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (mct_end === 1'b1) begin
        at = cyc;
        break;
      end
    end
    seen = (at >= 0) ? 1 : 0;
    check({name, "_seen"}, seen, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : directed
    int e0, e1, e2, e3;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and warm-up: 8 clks of tp=0, then T01, T02 two clks later.
    check("rst_state", 32'(state), 1);
    check("rst_mct_cnt", 32'(mct_cnt), 0);
    check("rst_mct_end", 32'(mct_end), 0);
    for (int i = 0; i < 8; i++) begin
      check("warm_tp_zero", 32'(tp), 0);
      @(negedge clk);
    end
    check("first_t01", 32'(tp), 'h001);
    check("run_state", 32'(state), 2);
    repeat (2) @(negedge clk);
    check("second_t02", 32'(tp), 'h002);

    // Three free-running MCTs, 24 clks apart.
    wait_end("mct1", e1);
    wait_end("mct2", e2);
    wait_end("mct3", e3);
    check("first_end_cycle", e1, 33);
    check("mct_period_a", e2 - e1, 24);
    check("mct_period_b", e3 - e2, 24);
    @(negedge clk);
    check("mct_cnt_3", 32'(mct_cnt), 3);
    check("t12_to_t01", 32'(tp), 'h001);

    // Standby requested during T05 completes the MCT, then STBY.
    repeat (8) @(negedge clk);
    check("t05", 32'(tp), 'h010);
    stby = 1'b1;
    wait_end("stby_end", e0);
    check("t12_at_stby_end", 32'(tp), 'h800);
    check("run_until_end", 32'(state), 2);
    @(negedge clk);
    check("stby_state", 32'(state), 0);
    check("stby_tp", 32'(tp), 0);
    check("mct_cnt_4", 32'(mct_cnt), 4);
    repeat (3) @(negedge clk);
    check("stby_hold", 32'(state), 0);
    stby = 1'b0;
    @(negedge clk);
    check("rewarm_state", 32'(state), 1);
    repeat (7) @(negedge clk);
    check("rewarm_last_tp", 32'(tp), 0);
    @(negedge clk);
    check("rewarm_t01", 32'(tp), 'h001);

    // Counter wrap from a forced 0xFFFF.
    force dut.mct_cnt_q = 16'hFFFF;
    m_cnt = 32'hFFFF;
    @(negedge clk);
    release dut.mct_cnt_q;
    @(negedge clk);
    check("forced_cnt_hold", 32'(mct_cnt), 'hFFFF);
    wait_end("wrap_end", e0);
    @(negedge clk);
    check("wrap_zero", 32'(mct_cnt), 0);

    // Reset during T07 aborts the MCT.
    repeat (12) @(negedge clk);
    check("t07", 32'(tp), 'h040);
    rst = 1'b1;
    #1;
    check("t07_rst_no_end", 32'(mct_end), 0);
    @(negedge clk);
    check("abort_state", 32'(state), 1);
    check("abort_tp", 32'(tp), 0);
    check("abort_mct_cnt", 32'(mct_cnt), 0);
    check("abort_mct_end", 32'(mct_end), 0);
    rst = 1'b0;

    // Reset on the last clk of T12: no end pulse, no increment.
    repeat (31) @(negedge clk);
    check("t12_last_clk", 32'(tp), 'h800);
    rst = 1'b1;
    #1;
    check("t12_rst_no_end", 32'(mct_end), 0);
    @(negedge clk);
    check("t12_rst_mct_cnt", 32'(mct_cnt), 0);
    check("t12_rst_state", 32'(state), 1);
    rst = 1'b0;

`ifdef TPG_STEP_EN
    // Stop, then single-step with extra mstrt pulses mid-step.
    begin : step_test
      int ends = 0;
      int n = 0;
      logic [11:0] seen_tp = '0;
      mstp = 1'b1;
      wait_end("pre_halt_end", e0);
      @(negedge clk);
      check("halt_state", 32'(state), 3);
      check("halt_tp", 32'(tp), 0);
      check("halt_mct_cnt", 32'(mct_cnt), 1);
      repeat (3) @(negedge clk);
      check("halt_hold", 32'(state), 3);
      mstrt = 1'b1;
      @(negedge clk);
      mstrt = 1'b0;
      check("step_t01", 32'(tp), 'h001);
      while (state != 2'd3 && n < 60) begin
        seen_tp = seen_tp | tp;
        if (mct_end) ends++;
        mstrt = (n == 5 || n == 6 || n == 15);
        @(negedge clk);
        n++;
      end
      mstrt = 1'b0;
      check("step_cycles", n, 24);
      check("step_end_pulses", ends, 1);
      check("step_all_tp", 32'(seen_tp), 'hFFF);
      check("step_mct_cnt", 32'(mct_cnt), 2);
      repeat (4) @(negedge clk);
      check("step_back_halt", 32'(state), 3);
      mstp = 1'b0;
      @(negedge clk);
      check("resume_run", 32'(state), 2);
      check("resume_t01", 32'(tp), 'h001);
    end
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
